// File: rtl/wb_camera_dma.sv
// Camera pixel-stream to Wishbone classic writer. Pixels are packed into words,
// buffered in a small FIFO, and each frame is written as a timestamp header followed by pixel words.
module wb_camera_dma #(
  parameter int ADR_WIDTH  = 15,
  parameter int PIX_WIDTH  = 8,
  parameter int DAT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PIX_WIDTH-1:0]   i_px_dat,
  input  logic                   i_px_vld,
  input  logic                   i_sof,
  input  logic                   i_eof,
  input  logic                   i_enable,
  input  logic [ADR_WIDTH-1:0]   i_wr_addr_start,
  input  logic [31:0]            i_timestamp,
  input  logic                   i_overrun_clr,
  output logic                   o_overrun,
  output logic                   o_frame_done,
  output logic [ADR_WIDTH-1:0]   o_words_written,
  output logic                   o_busy,
  output logic                   m_wb_cyc,
  output logic                   m_wb_stb,
  output logic [ADR_WIDTH-1:0]   m_wb_adr,
  output logic [DAT_WIDTH-1:0]   m_o_wb_dat,
  output logic [DAT_WIDTH/8-1:0] m_wb_sel,
  output logic                   m_wb_we,
  input  logic                   m_wb_ack
);

  localparam int PPW   = DAT_WIDTH / PIX_WIDTH;
  localparam int CNT_W = $clog2(PPW + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = DAT_WIDTH + 2;
  localparam logic [ADR_WIDTH-1:0] ADR_STEP = ADR_WIDTH'(DAT_WIDTH / 8);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  function automatic logic [DAT_WIDTH-1:0] ts_ext(input logic [31:0] ts);
    logic [DAT_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < DAT_WIDTH && i < 32; i++) r[i] = ts[i];
    return r;
  endfunction

  logic                 act_q, act_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DAT_WIDTH-1:0] pkw_q, pkw_d, px_word;
  logic                 push, push_sof, push_eof;
  logic [DAT_WIDTH-1:0] push_dat;

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW:0]          wptr_q, rptr_q;
  logic                 full, empty, pop;
  logic [EW-1:0]        rd_ent;
  logic                 ovr_q, ovr_d;

  state_t               state_q, state_d;
  logic                 cyc_q, cyc_d, eof_q, eof_d, done_q, done_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d, words_q, words_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;

  // Packer word with the current pixel merged into its slot (unused slots stay zero).
  always_comb begin
    px_word = pkw_q;
    for (int k = 0; k < PPW; k++)
      if (i_px_vld && CNT_W'(k) == cnt_q) px_word[k*PIX_WIDTH +: PIX_WIDTH] = i_px_dat;
  end

  always_comb begin
    act_d    = act_q;
    cnt_d    = cnt_q;
    pkw_d    = pkw_q;
    push     = 1'b0;
    push_sof = 1'b0;
    push_eof = 1'b0;
    push_dat = px_word;
    if (i_sof && i_enable) begin
      act_d    = 1'b1;
      push     = 1'b1;
      push_sof = 1'b1;
      push_dat = ts_ext(i_timestamp);
      pkw_d    = '0;
      cnt_d    = '0;
      if (i_px_vld) begin
        pkw_d[PIX_WIDTH-1:0] = i_px_dat;
        cnt_d                = CNT_W'(1);
      end
    end else if (act_q) begin
      if (i_eof) begin
        push     = 1'b1;
        push_eof = 1'b1;
        act_d    = 1'b0;
        cnt_d    = '0;
        pkw_d    = '0;
      end else if (i_px_vld) begin
        if (cnt_q == CNT_W'(PPW - 1)) begin
          push  = 1'b1;
          cnt_d = '0;
          pkw_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          pkw_d = px_word;
        end
      end
    end
  end

  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty  = (wptr_q == rptr_q);
  assign rd_ent = mem_q[rptr_q[AW-1:0]];
  assign ovr_d  = (push && full) ? 1'b1 : (i_overrun_clr ? 1'b0 : ovr_q);

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wptr_q[AW-1:0]] <= {push_sof, push_eof, push_dat};
  end

  // Bus FSM: one entry popped per transfer; SOF entries rebase the address.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    eof_d   = eof_q;
    words_d = words_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cyc_d   = 1'b1;
          dat_d   = rd_ent[DAT_WIDTH-1:0];
          eof_d   = rd_ent[EW-2];
          state_d = S_REQ;
          if (rd_ent[EW-1]) begin
            adr_d   = i_wr_addr_start;
            words_d = '0;
          end
        end
      end
      S_REQ: begin
        if (m_wb_ack) begin
          cyc_d   = 1'b0;
          adr_d   = adr_q + ADR_STEP;
          words_d = words_q + ADR_WIDTH'(1);
          done_d  = eof_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q   <= 1'b0;
      cnt_q   <= '0;
      pkw_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovr_q   <= 1'b0;
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      eof_q   <= 1'b0;
      words_q <= '0;
      done_q  <= 1'b0;
    end else begin
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      pkw_q   <= pkw_d;
      if (push && !full) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop) rptr_q <= rptr_q + (AW+1)'(1);
      ovr_q   <= ovr_d;
      state_q <= state_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      eof_q   <= eof_d;
      words_q <= words_d;
      done_q  <= done_d;
    end
  end

  assign o_overrun       = ovr_q;
  assign o_frame_done    = done_q;
  assign o_words_written = words_q;
  assign o_busy          = act_q || !empty || cyc_q;
  assign m_wb_cyc        = cyc_q;
  assign m_wb_stb        = cyc_q;
  assign m_wb_adr        = adr_q;
  assign m_o_wb_dat      = dat_q;
  assign m_wb_sel        = '1;
  assign m_wb_we         = 1'b1;

endmodule

// File: tb/tb_wb_camera_dma.sv
// Bench for wb_camera_dma: table of frames plus randomized frames against a frame-level model,
// with hand sequences for overrun, reset during a transfer and a 10-bit/64-bit instance.
module tb_wb_camera_dma;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [7:0]  i_px_dat = 0;
  logic        i_px_vld = 0, i_sof = 0, i_eof = 0, i_enable = 0, i_overrun_clr = 0;
  logic [14:0] i_wr_addr_start = 0;
  logic [31:0] i_timestamp = 0;
  logic        o_overrun, o_frame_done, o_busy, m_wb_cyc, m_wb_stb, m_wb_we;
  logic [14:0] o_words_written, m_wb_adr;
  logic [31:0] m_o_wb_dat;
  logic [3:0]  m_wb_sel;
  logic        m_wb_ack = 0;

  logic [9:0]  b_px_dat = 0;
  logic        b_px_vld = 0, b_sof = 0, b_eof = 0, b_enable = 0;
  logic [14:0] b_base = 0;
  logic [31:0] b_ts = 0;
  logic        b_overrun, b_done, b_busy, b_cyc, b_stb, b_we;
  logic [14:0] b_words, b_adr;
  logic [63:0] b_dat;
  logic [7:0]  b_sel;
  logic        b_ack = 0;

  wb_camera_dma u_dut (
    .clk(clk), .rst_n(rst_n), .i_px_dat(i_px_dat), .i_px_vld(i_px_vld), .i_sof(i_sof),
    .i_eof(i_eof), .i_enable(i_enable), .i_wr_addr_start(i_wr_addr_start),
    .i_timestamp(i_timestamp), .i_overrun_clr(i_overrun_clr), .o_overrun(o_overrun),
    .o_frame_done(o_frame_done), .o_words_written(o_words_written), .o_busy(o_busy),
    .m_wb_cyc(m_wb_cyc), .m_wb_stb(m_wb_stb), .m_wb_adr(m_wb_adr), .m_o_wb_dat(m_o_wb_dat),
    .m_wb_sel(m_wb_sel), .m_wb_we(m_wb_we), .m_wb_ack(m_wb_ack));

  wb_camera_dma #(.ADR_WIDTH(15), .PIX_WIDTH(10), .DAT_WIDTH(64), .FIFO_DEPTH(4)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .i_px_dat(b_px_dat), .i_px_vld(b_px_vld), .i_sof(b_sof),
    .i_eof(b_eof), .i_enable(b_enable), .i_wr_addr_start(b_base), .i_timestamp(b_ts),
    .i_overrun_clr(1'b0), .o_overrun(b_overrun), .o_frame_done(b_done),
    .o_words_written(b_words), .o_busy(b_busy), .m_wb_cyc(b_cyc), .m_wb_stb(b_stb),
    .m_wb_adr(b_adr), .m_o_wb_dat(b_dat), .m_wb_sel(b_sel), .m_wb_we(b_we), .m_wb_ack(b_ack));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int done_cnt = 0, b_done_cnt = 0;
  bit ack_en = 1;
  int px_buf [64];
  logic [14:0] got_adr[$], exp_adr[$], b_got_adr[$], b_exp_adr[$];
  logic [63:0] got_dat[$], exp_dat[$], b_got_dat[$], b_exp_dat[$];

  typedef struct {
    logic [14:0] base; logic [31:0] ts; int n; int first;
    bit eof_last; bit en; bit drop; bit sof_px;
    int exp_n; logic [31:0] exp_last;
  } vec_t;
  vec_t tbl [7];

  initial forever begin
    @(posedge clk);
    assert (!(i_sof && i_eof)) else $error("illegal sof+eof in one cycle");
  end

  // Slave: zero-wait ack, writes captured when ack is raised.
  initial forever begin
    @(negedge clk);
    if (o_frame_done) done_cnt++;
    if (m_wb_ack) m_wb_ack = 0;
    else if (ack_en && m_wb_cyc && m_wb_stb && rst_n) begin
      m_wb_ack = 1; got_adr.push_back(m_wb_adr); got_dat.push_back(64'(m_o_wb_dat));
    end
  end

  initial forever begin
    @(negedge clk);
    if (b_done) b_done_cnt++;
    if (b_ack) b_ack = 0;
    else if (b_cyc && b_stb && rst_n) begin
      b_ack = 1; b_got_adr.push_back(b_adr); b_got_dat.push_back(b_dat);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model: header, then pixels grouped ppw per word, LSB first.
  task automatic model_frame(input int inst, input int pw, input int ppw, input int step,
                             input logic [14:0] base, input logic [31:0] ts, input int n,
                             input bit eof_last, output int nw);
    logic [63:0] w;
    logic [14:0] a;
    int ndata;
    ndata = eof_last ? (n + ppw - 1) / ppw : n / ppw + 1;
    nw = ndata + 1;
    for (int j = 0; j < nw; j++) begin
      a = base + 15'(step * j);
      w = (j == 0) ? 64'(ts) : 64'd0;
      if (j > 0)
        for (int i = (j - 1) * ppw; i < j * ppw && i < n; i++)
          w = w | (64'(px_buf[i]) << (pw * (i - (j - 1) * ppw)));
      if (inst == 1) begin exp_adr.push_back(a); exp_dat.push_back(w); end
      else begin b_exp_adr.push_back(a); b_exp_dat.push_back(w); end
    end
  endtask

  task automatic send_frame(input logic [14:0] base, input logic [31:0] ts, input int n,
                            input bit eof_last, input bit en, input bit drop,
                            input bit sof_px, input int gap_max);
    int idx = 0;
    @(negedge clk);
    i_sof = 1; i_enable = en; i_wr_addr_start = base; i_timestamp = ts;
    if (sof_px && n > 0 && !(n == 1 && eof_last)) begin
      i_px_vld = 1; i_px_dat = 8'(px_buf[0]); idx = 1;
    end
    @(negedge clk);
    i_sof = 0; i_px_vld = 0;
    if (drop) i_enable = 0;
    while (idx < n) begin
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      i_px_vld = 1; i_px_dat = 8'(px_buf[idx]);
      if (idx == n - 1 && eof_last) i_eof = 1;
      idx++;
      @(negedge clk);
      i_px_vld = 0; i_eof = 0;
    end
    if (!eof_last) begin
      i_eof = 1; @(negedge clk); i_eof = 0;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c = 0;
    repeat (2) @(negedge clk);
    while ((o_busy || m_wb_cyc) && c < budget) begin @(negedge clk); c++; end
    if (c >= budget) begin
      checks++; failures++;
      $display("FAIL %s_idle_timeout actual=busy required=idle", tag);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_frame(input string tag, input logic [14:0] base, input logic [31:0] ts,
                          input int n, input bit eof_last, input bit en, input bit drop,
                          input bit sof_px, input int gap_max);
    int nw = 0;
    int d0;
    got_adr.delete(); got_dat.delete(); exp_adr.delete(); exp_dat.delete();
    d0 = done_cnt;
    if (en) model_frame(1, 8, 4, 4, base, ts, n, eof_last, nw);
    send_frame(base, ts, n, eof_last, en, drop, sof_px, gap_max);
    wait_idle(tag, 3000);
    chk($sformatf("%s_nwrites", tag), 64'(got_adr.size()), 64'(exp_adr.size()));
    for (int i = 0; i < got_adr.size() && i < exp_adr.size(); i++) begin
      chk($sformatf("%s_adr%0d", tag, i), 64'(got_adr[i]), 64'(exp_adr[i]));
      chk($sformatf("%s_dat%0d", tag, i), got_dat[i], exp_dat[i]);
    end
    chk($sformatf("%s_done", tag), 64'(done_cnt - d0), en ? 64'd1 : 64'd0);
    if (en) chk($sformatf("%s_words", tag), 64'(o_words_written), 64'(nw));
  endtask

  initial begin
    int nw;
    logic [63:0] w;
    tbl[0] = '{15'h100,  32'hCAFE0001, 8, 8'h01, 1, 1, 0, 0, 3, 32'h08070605};
    tbl[1] = '{15'h200,  32'h12345678, 6, 8'h11, 0, 1, 0, 1, 3, 32'h00001615};
    tbl[2] = '{15'h7FF8, 32'h0000BEEF, 4, 8'hA0, 0, 1, 0, 0, 3, 32'h00000000};
    tbl[3] = '{15'h300,  32'h00000001, 5, 8'h40, 1, 0, 0, 0, 0, 32'h00000000};
    tbl[4] = '{15'h304,  32'h00000002, 0, 8'h00, 0, 1, 0, 0, 2, 32'h00000000};
    tbl[5] = '{15'h000,  32'h00000003, 5, 8'h31, 1, 1, 1, 1, 3, 32'h00000035};
    tbl[6] = '{15'h010,  32'h00000004, 9, 8'h01, 1, 1, 0, 0, 4, 32'h00000009};

    repeat (3) @(negedge clk);
    chk("rst_cyc", 64'(m_wb_cyc), 0);
    chk("rst_stb", 64'(m_wb_stb), 0);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_overrun", 64'(o_overrun), 0);
    chk("rst_words", 64'(o_words_written), 0);
    chk("rst_adr", 64'(m_wb_adr), 0);
    chk("rst_sel", 64'(m_wb_sel), 64'hF);
    chk("rst_we", 64'(m_wb_we), 1);
    rst_n = 1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < tbl[t].n; i++) px_buf[i] = (tbl[t].first + i) & 8'hFF;
      do_frame($sformatf("tbl%0d", t), tbl[t].base, tbl[t].ts, tbl[t].n, tbl[t].eof_last,
               tbl[t].en, tbl[t].drop, tbl[t].sof_px, 0);
      chk($sformatf("tbl%0d_count", t), 64'(got_dat.size()), 64'(tbl[t].exp_n));
      if (tbl[t].exp_n > 0 && got_dat.size() > 0)
        chk($sformatf("tbl%0d_last", t), got_dat[got_dat.size()-1], 64'(tbl[t].exp_last));
    end

    for (int r = 0; r < 12; r++) begin
      int n;
      bit el;
      n = $urandom_range(20, 0);
      el = (n > 0) ? 1'($urandom_range(1, 0)) : 1'b0;
      for (int i = 0; i < n; i++) px_buf[i] = $urandom_range(255, 0);
      do_frame($sformatf("rnd%0d", r), 15'($urandom) & 15'h7FFC, $urandom, n, el,
               ($urandom_range(5, 0) != 0), 1'($urandom_range(1, 0)),
               1'($urandom_range(1, 0)), 2);
    end

    // Overrun with the slave stalled, then set/clear interplay.
    ack_en = 0;
    for (int i = 0; i < 32; i++) px_buf[i] = i;
    send_frame(15'h400, 32'h0BAD0BAD, 32, 1, 1, 0, 0, 0);
    chk("ovr_set", 64'(o_overrun), 1);
    chk("ovr_hold_cyc", 64'(m_wb_cyc), 1);
    chk("ovr_hold_adr", 64'(m_wb_adr), 64'h400);
    repeat (8) @(negedge clk);
    chk("ovr_sticky", 64'(o_overrun), 1);
    i_sof = 1; i_enable = 1; i_overrun_clr = 1;
    @(negedge clk);
    i_sof = 0; i_overrun_clr = 0;
    chk("ovr_set_wins_clr", 64'(o_overrun), 1);
    i_overrun_clr = 1; @(negedge clk); i_overrun_clr = 0;
    chk("ovr_cleared", 64'(o_overrun), 0);
    i_eof = 1; @(negedge clk); i_eof = 0;
    chk("ovr_eof_drop", 64'(o_overrun), 1);
    i_overrun_clr = 1; @(negedge clk); i_overrun_clr = 0;
    chk("ovr_cleared2", 64'(o_overrun), 0);
    ack_en = 1;
    wait_idle("ovr_drain", 3000);
    chk("ovr_after_drain", 64'(o_overrun), 0);

    // Reset while a request is open.
    ack_en = 0;
    for (int i = 0; i < 4; i++) px_buf[i] = 8'h50 + i;
    send_frame(15'h500, 32'h11112222, 4, 1, 1, 0, 0, 0);
    chk("req_open", 64'(m_wb_cyc), 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_cyc", 64'(m_wb_cyc), 0);
    chk("arst_stb", 64'(m_wb_stb), 0);
    chk("arst_busy", 64'(o_busy), 0);
    chk("arst_words", 64'(o_words_written), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    ack_en = 1;
    do_frame("post_rst", 15'h500, 32'h33334444, 4, 1, 1, 0, 0, 1);

    // 10-bit pixels into 64-bit words.
    b_got_adr.delete(); b_got_dat.delete();
    for (int i = 0; i < 8; i++) px_buf[i] = $urandom_range(1023, 0);
    model_frame(2, 10, 6, 8, 15'h40, 32'hDEADBEEF, 8, 1, nw);
    @(negedge clk);
    b_sof = 1; b_enable = 1; b_base = 15'h40; b_ts = 32'hDEADBEEF;
    @(negedge clk);
    b_sof = 0;
    for (int i = 0; i < 8; i++) begin
      b_px_vld = 1; b_px_dat = 10'(px_buf[i]); b_eof = (i == 7);
      @(negedge clk);
      b_px_vld = 0; b_eof = 0;
    end
    begin
      int c = 0;
      repeat (2) @(negedge clk);
      while ((b_busy || b_cyc) && c < 500) begin @(negedge clk); c++; end
      if (c >= 500) begin
        checks++; failures++;
        $display("FAIL w64_idle_timeout actual=busy required=idle");
      end
      repeat (3) @(negedge clk);
    end
    chk("w64_nwrites", 64'(b_got_adr.size()), 64'(b_exp_adr.size()));
    for (int i = 0; i < b_got_adr.size() && i < b_exp_adr.size(); i++) begin
      chk($sformatf("w64_adr%0d", i), 64'(b_got_adr[i]), 64'(b_exp_adr[i]));
      chk($sformatf("w64_dat%0d", i), b_got_dat[i], b_exp_dat[i]);
    end
    if (b_got_dat.size() > 1) begin
      w = b_got_dat[1];
      chk("w64_px5", 64'(w[59:50]), 64'(px_buf[5]));
      chk("w64_pad", 64'(w[63:60]), 0);
    end
    chk("w64_done", 64'(b_done_cnt), 1);
    chk("w64_words", 64'(b_words), 64'(nw));
    chk("w64_sel", 64'(b_sel), 64'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
